// File: rtl/gat_feat_reader_if.sv
// Feature stream bundle from the readback engine to the output DMA.
// The master drives data, valid and last. The slave drives ready.
interface gat_feat_reader_if #(
    parameter int W = 32
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/gat_feat_reader.sv
// Sweeps the GAT new-feature BRAM and streams the words out on valid/ready.
// A credit count covers in-flight reads plus FIFO occupancy, so a stall never drops data.
module gat_feat_reader #(
    parameter int NEW_FEATURE_WIDTH  = 32,
    parameter int NEW_FEATURE_DEPTH  = 43328,
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int RD_LATENCY         = 2,
    parameter int FIFO_DEPTH         = RD_LATENCY + 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          gat_ready,
    input  logic                          start,
    input  logic [NEW_FEATURE_ADDR_W:0]   num_words,
    output logic                          busy,
    output logic                          done,
    output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
    gat_feat_reader_if.master             m
);
    localparam int CW = NEW_FEATURE_ADDR_W + 1;
    localparam int BW = NEW_FEATURE_ADDR_W + 2;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int KW = $clog2(FIFO_DEPTH + 1);
    localparam logic [KW-1:0] FD_K   = KW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_P = PW'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_RDY, READ, DRAIN, DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          num_q, issue_q, out_q;
    logic [CW-1:0]          issue_nx;
    logic [BW-1:0]          addr_q, issue_addr;
    logic [RD_LATENCY-1:0]  pipe_q, pipe_d;
    logic [NEW_FEATURE_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wr_q, rd_q;
    logic [KW-1:0]          cnt_q, cnt_d, cred_q, cred_d;
    logic                   issue, push, pop, accept;

    assign issue_nx   = issue_q + 1'b1;
    assign issue_addr = {issue_q[CW-2:0], 2'b00};
    assign accept     = (state_q == IDLE) && start;
    assign push       = pipe_q[RD_LATENCY-1];
    assign pop        = m.tvalid && m.tready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start) state_d = (num_words == '0) ? DONE : WAIT_RDY;
            WAIT_RDY: if (gat_ready) state_d = READ;
            READ:     if (issue && (issue_nx == num_q)) state_d = DRAIN;
            DRAIN:    if (pop && m.tlast) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        issue    = (state_q == READ) && gat_ready && (cred_q < FD_K);
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        m.tvalid = (cnt_q != '0);
        m.tdata  = m.tvalid ? mem_q[rd_q] : '0;
        m.tlast  = m.tvalid && (out_q == num_q - 1'b1);
        feat_bram_addrb = issue ? issue_addr : addr_q;
    end

    always_comb begin
        pipe_d    = pipe_q << 1;
        pipe_d[0] = issue;
        cnt_d     = cnt_q;
        cred_d    = cred_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        unique case ({issue, pop})
            2'b10:   cred_d = cred_q + 1'b1;
            2'b01:   cred_d = cred_q - 1'b1;
            default: cred_d = cred_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_q   <= '0;
            issue_q <= '0;
            out_q   <= '0;
            addr_q  <= '0;
            pipe_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            cred_q  <= '0;
        end else begin
            if (accept) begin
                num_q   <= num_words;
                issue_q <= '0;
                out_q   <= '0;
            end else begin
                if (issue) issue_q <= issue_nx;
                if (pop)   out_q   <= out_q + 1'b1;
            end
            if (issue) addr_q <= issue_addr;
            pipe_q <= pipe_d;
            if (push) wr_q <= (wr_q == LAST_P) ? '0 : wr_q + 1'b1;
            if (pop)  rd_q <= (rd_q == LAST_P) ? '0 : rd_q + 1'b1;
            cnt_q  <= cnt_d;
            cred_q <= cred_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= feat_bram_dout;
    end
endmodule

// File: tb/tb_gat_feat_reader.sv
// Randomized bench for gat_feat_reader with a BRAM model and an in-order
// expected word stream derived from the transfer length.
module tb_gat_feat_reader;
    localparam int W  = 32;
    localparam int D  = 43328;
    localparam int AW = $clog2(D);
    localparam int L  = 2;
    localparam int FD = L + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          gat_ready = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   num_words = '0;
    logic          busy, done;
    logic [AW+1:0] addrb;
    logic [W-1:0]  dout;
    logic [W-1:0]  rd_pipe [L];
    logic [31:0]   seed = 32'h0;
    int            n_cmp = 0;
    int            n_bad = 0;

    gat_feat_reader_if #(.W(W)) m_if ();

    gat_feat_reader #(
        .NEW_FEATURE_WIDTH(W), .NEW_FEATURE_DEPTH(D),
        .RD_LATENCY(L), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .gat_ready(gat_ready), .start(start),
        .num_words(num_words), .busy(busy), .done(done),
        .feat_bram_addrb(addrb), .feat_bram_dout(dout), .m(m_if)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] word_at(input int i);
        return seed ^ (32'h1000 + i);
    endfunction

    always @(posedge clk) begin
        rd_pipe[0] <= word_at(int'(addrb >> 2));
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign dout = rd_pipe[L-1];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_addr"}, 64'(addrb), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_v"}, 64'(m_if.tvalid), 64'(0));
        check({tag, "_l"}, 64'(m_if.tlast), 64'(0));
        check({tag, "_d"}, 64'(m_if.tdata), 64'(0));
    endtask

    // Called at posedge+1. rmode: 0 ready high, 1 pattern 1-0-0-1, 2 random.
    task automatic xfer(input int n, input int rmode, input int lo_pre,
                        input int drop_k, input bit restart, input int abort_at);
        int k, got, last_k, first_k;
        bit fin, stall, prev_last, aborted;
        logic [W-1:0] prev_data;
        logic [AW+1:0] prev_addr, max_addr;
        gat_ready = (lo_pre == 0);
        start = 1'b1;
        num_words = n[AW:0];
        @(posedge clk); #1;
        start = 1'b0;
        k = 0; got = 0; last_k = -1; first_k = -1;
        fin = 0; stall = 0; prev_last = 0; aborted = 0;
        prev_data = '0; prev_addr = addrb; max_addr = '0;
        while (!fin && k < n + 200) begin
            k++;
            gat_ready = !((k <= lo_pre) ||
                          (drop_k > 0 && k >= drop_k && k < drop_k + 3));
            start = restart && (k == 3);
            num_words = (restart && k == 3) ? 17'd5 : n[AW:0];
            unique case (rmode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = (k % 4 == 0) || (k % 4 == 3);
                default: m_if.tready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            check("addr_lsb", 64'(addrb[1:0]), 64'(0));
            check("fifo_occ", 64'(dut.cnt_q <= FD), 64'(1));
            if (!gat_ready) check("addr_hold", 64'(addrb), 64'(prev_addr));
            if (addrb != prev_addr && addrb > max_addr) max_addr = addrb;
            if (stall) begin
                check("stall_v", 64'(m_if.tvalid), 64'(1));
                check("stall_d", 64'(m_if.tdata), 64'(prev_data));
                check("stall_l", 64'(m_if.tlast), 64'(prev_last));
            end
            if (m_if.tvalid && first_k < 0) begin
                first_k = k;
                if (lo_pre == 0) check("first_valid", 64'(k), 64'(5));
            end
            if (n == 0) begin
                check("zero_v", 64'(m_if.tvalid), 64'(0));
                check("zero_a", 64'(addrb), 64'(0));
            end
            if (done) begin
                fin = 1;
                check("done_cyc", 64'(k), (n == 0) ? 64'(1) : 64'(last_k + 1));
            end else begin
                check("busy", 64'(busy), 64'(1));
            end
            if (m_if.tvalid && m_if.tready) begin
                check("data", 64'(m_if.tdata), 64'(word_at(got)));
                check("last", 64'(m_if.tlast), 64'(got == n - 1));
                if (got == n - 1) last_k = k;
                got++;
            end
            stall = m_if.tvalid && !m_if.tready;
            prev_data = m_if.tdata;
            prev_last = m_if.tlast;
            prev_addr = addrb;
            if (abort_at > 0 && got == abort_at) begin
                aborted = 1;
                fin = 1;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (aborted) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            check_reset_outs("abort");
            repeat (3) begin
                @(negedge clk);
                check("post_rst_v", 64'(m_if.tvalid), 64'(0));
            end
            @(posedge clk); #1;
        end else begin
            check("timeout", 64'(fin), 64'(1));
            check("count", 64'(got), 64'(n));
            check("max_addr", 64'(max_addr),
                  (n > 0) ? 64'((n - 1) * 4) : 64'(0));
            @(negedge clk);
            check("busy_off", 64'(busy), 64'(0));
            check("done_off", 64'(done), 64'(0));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        m_if.tready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outs("idle");
        @(posedge clk); #1;

        seed = 32'h0;
        xfer(0, 0, 0, 0, 0, 0);
        xfer(4, 0, 0, 0, 0, 0);
        seed = $urandom();
        xfer(16, 1, 0, 0, 0, 0);
        seed = $urandom();
        xfer(24, 0, 10, 20, 0, 0);
        seed = $urandom();
        xfer(20, 0, 0, 0, 1, 5);
        seed = $urandom();
        xfer(6, 2, 0, 0, 0, 0);
        for (int t = 0; t < 6; t++) begin
            seed = $urandom();
            xfer(int'($urandom_range(1, 40)), int'($urandom_range(0, 2)),
                 0, 0, 0, 0);
        end
        seed = $urandom();
        xfer(D, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
